// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the button conditioner: debounce state
// encoding, button index assignments and the stability counter width.
package button_conditioner_pkg;

   localparam int CNT_W   = 8;
   localparam int NUM_BTN = 3;

   localparam int BTN_WR  = 0;
   localparam int BTN_INC = 1;
   localparam int BTN_DEC = 2;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_HELD         = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } db_state_e;

endpackage

// File: rtl/button_conditioner_debounce.sv
// One button channel: 2-flop synchronizer, polarity fix-up and a debounce
// FSM whose stability counter only advances on i_ena ticks.
module button_debounce
   import button_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = 4,
   parameter int BTN_ACTIVE_LOW = 1
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_ena,
   input  logic i_btn_raw,
   output logic o_level,
   output logic o_press,
   output logic o_held
);

   localparam logic [CNT_W-1:0] TARGET = CNT_W'(DEBOUNCE_TICKS);
   localparam bit SINGLE_TICK = (DEBOUNCE_TICKS <= 1);

   logic             sync1_q, sync2_q;
   logic             pressed;
   db_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             press_d;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= i_btn_raw;
         sync2_q <= sync1_q;
      end
   end

   assign pressed = (BTN_ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

   // A single stable tick already satisfies a threshold of one, so skip the wait states.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      if (i_ena) begin
         case (state_q)
            ST_IDLE: begin
               if (pressed) begin
                  if (SINGLE_TICK) begin
                     state_d = ST_HELD;
                     cnt_d   = '0;
                     press_d = 1'b1;
                  end else begin
                     state_d = ST_PRESS_WAIT;
                     cnt_d   = CNT_W'(1);
                  end
               end
            end
            ST_PRESS_WAIT: begin
               if (!pressed) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else if (cnt_q + CNT_W'(1) >= TARGET) begin
                  state_d = ST_HELD;
                  cnt_d   = '0;
                  press_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_HELD: begin
               if (!pressed) begin
                  if (SINGLE_TICK) begin
                     state_d = ST_IDLE;
                     cnt_d   = '0;
                  end else begin
                     state_d = ST_RELEASE_WAIT;
                     cnt_d   = CNT_W'(1);
                  end
               end
            end
            ST_RELEASE_WAIT: begin
               if (pressed) begin
                  state_d = ST_HELD;
                  cnt_d   = '0;
               end else if (cnt_q + CNT_W'(1) >= TARGET) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
      level_d = (state_d == ST_HELD) || (state_d == ST_RELEASE_WAIT);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign o_level = level_q;
   assign o_press = press_d;
   assign o_held  = (state_q == ST_HELD);

endmodule

// File: rtl/button_conditioner.sv
// Three-button conditioner: per-button debounce, i_ena-aligned event pulses and
// inc/dec conflict suppression. Define BUTTON_AUTOREPEAT_EN for inc/dec auto-repeat.
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = 4,
   parameter int BTN_ACTIVE_LOW = 1,
   parameter int REPEAT_DELAY   = 50,
   parameter int REPEAT_PERIOD  = 10
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic               i_ena,
   input  logic [NUM_BTN-1:0] i_btn,
   output logic               o_wr_pulse,
   output logic               o_sel_inc_pulse,
   output logic               o_sel_dec_pulse,
   output logic [NUM_BTN-1:0] o_btn_level
);

   logic [NUM_BTN-1:0] press, held, level;
   logic               rep_inc, rep_dec;
   logic               unused_held;
   logic               inc_evt, dec_evt;
   logic               wr_q, wr_d, inc_q, inc_d, dec_q, dec_d;

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      button_debounce #(
         .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
         .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)
      ) u_debounce (
         .i_clk    (i_clk),
         .i_reset_n(i_reset_n),
         .i_ena    (i_ena),
         .i_btn_raw(i_btn[g]),
         .o_level  (level[g]),
         .o_press  (press[g]),
         .o_held   (held[g])
      );
   end

`ifdef BUTTON_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] REP_DELAY_T  = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] REP_PERIOD_T = CNT_W'(REPEAT_PERIOD);

   logic [1:0][CNT_W-1:0] rep_cnt_q, rep_cnt_d;
   logic [1:0]            rep_phase_q, rep_phase_d;
   logic [1:0]            rep_evt;

   // Index 0 tracks increment, 1 tracks decrement; phase 1 means the initial delay has elapsed.
   always_comb begin
      rep_cnt_d   = rep_cnt_q;
      rep_phase_d = rep_phase_q;
      rep_evt     = '0;
      for (int i = 0; i < 2; i++) begin
         if (!held[BTN_INC + i]) begin
            rep_cnt_d[i]   = '0;
            rep_phase_d[i] = 1'b0;
         end else if (i_ena) begin
            if (rep_cnt_q[i] + CNT_W'(1) >= (rep_phase_q[i] ? REP_PERIOD_T : REP_DELAY_T)) begin
               rep_evt[i]     = 1'b1;
               rep_cnt_d[i]   = '0;
               rep_phase_d[i] = 1'b1;
            end else begin
               rep_cnt_d[i] = rep_cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rep_cnt_q   <= '0;
         rep_phase_q <= '0;
      end else begin
         rep_cnt_q   <= rep_cnt_d;
         rep_phase_q <= rep_phase_d;
      end
   end

   assign rep_inc     = rep_evt[0];
   assign rep_dec     = rep_evt[1];
   assign unused_held = held[BTN_WR];
`else
   assign rep_inc     = 1'b0;
   assign rep_dec     = 1'b0;
   assign unused_held = ^held;
`endif

   assign inc_evt = press[BTN_INC] | rep_inc;
   assign dec_evt = press[BTN_DEC] | rep_dec;

   // Events only arise on i_ena ticks, so a new event wins over the clear of the previous pulse.
   always_comb begin
      wr_d  = press[BTN_WR]       ? 1'b1 : (i_ena ? 1'b0 : wr_q);
      inc_d = (inc_evt & ~dec_evt) ? 1'b1 : (i_ena ? 1'b0 : inc_q);
      dec_d = (dec_evt & ~inc_evt) ? 1'b1 : (i_ena ? 1'b0 : dec_q);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_q  <= 1'b0;
         inc_q <= 1'b0;
         dec_q <= 1'b0;
      end else begin
         wr_q  <= wr_d;
         inc_q <= inc_d;
         dec_q <= dec_d;
      end
   end

   assign o_wr_pulse      = wr_q;
   assign o_sel_inc_pulse = inc_q;
   assign o_sel_dec_pulse = dec_q;
   assign o_btn_level     = level;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: expected pulse events are queued
// as stimulus is driven and compared against events captured by a monitor.
module tb_button_conditioner;

   localparam int DB = 4;
   localparam int RD = 50;
   localparam int RP = 10;

   typedef struct {
      int btn;
      int tick;
      int width;
      int hits;
   } ev_t;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic       ena   = 1'b0;
   logic [2:0] btn   = 3'b111;
   logic       o_wr_pulse, o_sel_inc_pulse, o_sel_dec_pulse;
   logic [2:0] o_btn_level;

   ev_t  exp_q[$];
   ev_t  obs_q[$];
   int   checks = 0;
   int   failures = 0;
   int   tick_cnt = 0;
   int   pw_width[3];
   int   pw_hits[3];
   int   pw_start[3];
   logic [2:0] prev_p = 3'b000;
   logic [2:0] lvl_seen = 3'b000;
   wire  [2:0] pulses = {o_sel_dec_pulse, o_sel_inc_pulse, o_wr_pulse};

   button_conditioner #(
      .DEBOUNCE_TICKS(DB),
      .BTN_ACTIVE_LOW(1),
      .REPEAT_DELAY  (RD),
      .REPEAT_PERIOD (RP)
   ) dut (
      .i_clk          (clk),
      .i_reset_n      (rst_n),
      .i_ena          (ena),
      .i_btn          (btn),
      .o_wr_pulse     (o_wr_pulse),
      .o_sel_inc_pulse(o_sel_inc_pulse),
      .o_sel_dec_pulse(o_sel_dec_pulse),
      .o_btn_level    (o_btn_level)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         repeat (4) @(posedge clk);
         #1 ena = 1'b1;
         @(posedge clk);
         #1 ena = 1'b0;
      end
   end

   // Pulses interrupted by reset are dropped so they never reach the scoreboard.
   always @(negedge clk) begin
      if (ena) tick_cnt++;
      lvl_seen = lvl_seen | o_btn_level;
      for (int b = 0; b < 3; b++) begin
         if (pulses[b] === 1'b1) begin
            if (prev_p[b] !== 1'b1) begin
               pw_start[b] = tick_cnt;
               pw_width[b] = 0;
               pw_hits[b]  = 0;
            end
            pw_width[b]++;
            if (ena) pw_hits[b]++;
         end else if (prev_p[b] === 1'b1 && rst_n === 1'b1) begin
            obs_q.push_back('{btn: b, tick: pw_start[b], width: pw_width[b], hits: pw_hits[b]});
         end
      end
      prev_p = pulses;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic wait_ticks(input int n);
      repeat (n) @(negedge clk iff ena);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (o_wr_pulse !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr: got %b want 0", o_wr_pulse); end
      checks++;
      if (o_sel_inc_pulse !== 1'b0) begin failures++; $display("[TB] FAIL reset_inc: got %b want 0", o_sel_inc_pulse); end
      checks++;
      if (o_sel_dec_pulse !== 1'b0) begin failures++; $display("[TB] FAIL reset_dec: got %b want 0", o_sel_dec_pulse); end
      checks++;
      if (o_btn_level !== 3'b000) begin failures++; $display("[TB] FAIL reset_level: got %b want 000", o_btn_level); end
      wait_ticks(1);
      rst_n = 1'b1;
      wait_ticks(DB + 2);
      checks++;
      if (obs_q.size() !== 0 || o_btn_level !== 3'b000) begin
         failures++;
         $display("[TB] FAIL reset_idle: got events=%0d level=%b want 0 and 000", obs_q.size(), o_btn_level);
      end
      obs_q.delete();
   endtask

   task automatic test_bounce;
      ev_t e, o;
      int  k = 0;
      for (int p = 0; p < 5; p++) begin
         btn[0] = (p % 2 == 0) ? 1'b0 : 1'b1;
         if (p == 4) k = tick_cnt;
         wait_ticks(2);
      end
      exp_q.push_back('{btn: 0, tick: k + DB, width: 5, hits: 1});
      wait_ticks(6);
      checks++;
      if (o_btn_level[0] !== 1'b1) begin failures++; $display("[TB] FAIL bounce_level_held: got %b want 1", o_btn_level[0]); end
      btn[0] = 1'b1;
      wait_ticks(DB + 3);
      checks++;
      if (o_btn_level[0] !== 1'b0) begin failures++; $display("[TB] FAIL bounce_level_released: got %b want 0", o_btn_level[0]); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL bounce_event: got none, want btn=%0d tick=%0d", e.btn, e.tick);
         end else begin
            o = obs_q.pop_front();
            if (o.btn !== e.btn || o.tick !== e.tick || o.width !== e.width || o.hits !== e.hits) begin
               failures++;
               $display("[TB] FAIL bounce_event: got btn=%0d tick=%0d width=%0d hits=%0d, want btn=%0d tick=%0d width=%0d hits=%0d",
                        o.btn, o.tick, o.width, o.hits, e.btn, e.tick, e.width, e.hits);
            end
         end
      end
      checks++;
      if (obs_q.size() !== 0) begin failures++; $display("[TB] FAIL bounce_extra: got %0d extra events want 0", obs_q.size()); end
      obs_q.delete();
   endtask

   task automatic test_glitch;
      lvl_seen = 3'b000;
      btn[1] = 1'b0;
      wait_ticks(DB - 1);
      btn[1] = 1'b1;
      wait_ticks(DB + 3);
      checks++;
      if (obs_q.size() !== 0) begin failures++; $display("[TB] FAIL glitch_event: got %0d events want 0", obs_q.size()); end
      checks++;
      if (lvl_seen[1] !== 1'b0) begin failures++; $display("[TB] FAIL glitch_level: got %b want 0", lvl_seen[1]); end
      obs_q.delete();
   endtask

   task automatic test_conflict;
      ev_t e, o;
      int  k;
      btn = 3'b001;
      wait_ticks(DB + 2);
      btn = 3'b111;
      wait_ticks(DB + 3);
      checks++;
      if (obs_q.size() !== 0) begin failures++; $display("[TB] FAIL conflict_incdec: got %0d events want 0", obs_q.size()); end
      obs_q.delete();
      k = tick_cnt;
      btn = 3'b000;
      exp_q.push_back('{btn: 0, tick: k + DB, width: 5, hits: 1});
      wait_ticks(DB + 2);
      btn = 3'b111;
      wait_ticks(DB + 3);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL conflict_wr: got none, want btn=%0d tick=%0d", e.btn, e.tick);
         end else begin
            o = obs_q.pop_front();
            if (o.btn !== e.btn || o.tick !== e.tick || o.width !== e.width || o.hits !== e.hits) begin
               failures++;
               $display("[TB] FAIL conflict_wr: got btn=%0d tick=%0d width=%0d hits=%0d, want btn=%0d tick=%0d width=%0d hits=%0d",
                        o.btn, o.tick, o.width, o.hits, e.btn, e.tick, e.width, e.hits);
            end
         end
      end
      checks++;
      if (obs_q.size() !== 0) begin failures++; $display("[TB] FAIL conflict_extra: got %0d extra events want 0", obs_q.size()); end
      obs_q.delete();
   endtask

   task automatic test_back_to_back;
      ev_t e, o;
      int  k;
      k = tick_cnt;
      btn[1] = 1'b0;
      exp_q.push_back('{btn: 1, tick: k + DB, width: 5, hits: 1});
      wait_ticks(DB + 1);
      btn[1] = 1'b1;
      wait_ticks(DB);
      k = tick_cnt;
      btn[1] = 1'b0;
      exp_q.push_back('{btn: 1, tick: k + DB, width: 5, hits: 1});
      wait_ticks(DB + 2);
      btn[1] = 1'b1;
      wait_ticks(DB + 3);
      k = tick_cnt;
      btn[2] = 1'b0;
      exp_q.push_back('{btn: 2, tick: k + DB, width: 5, hits: 1});
      wait_ticks(DB + 2);
      btn[2] = 1'b1;
      wait_ticks(DB + 3);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL pulse_event: got none, want btn=%0d tick=%0d", e.btn, e.tick);
         end else begin
            o = obs_q.pop_front();
            if (o.btn !== e.btn || o.tick !== e.tick || o.width !== e.width || o.hits !== e.hits) begin
               failures++;
               $display("[TB] FAIL pulse_event: got btn=%0d tick=%0d width=%0d hits=%0d, want btn=%0d tick=%0d width=%0d hits=%0d",
                        o.btn, o.tick, o.width, o.hits, e.btn, e.tick, e.width, e.hits);
            end
         end
      end
      checks++;
      if (obs_q.size() !== 0) begin failures++; $display("[TB] FAIL pulse_extra: got %0d extra events want 0", obs_q.size()); end
      obs_q.delete();
   endtask

   task automatic test_reset_mid_pulse;
      ev_t e, o;
      int  k;
      int  n = 0;
      btn[2] = 1'b0;
      while (o_sel_dec_pulse !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (o_sel_dec_pulse !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_wait: dec pulse got %b want 1 within 100 cycles", o_sel_dec_pulse); end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({o_wr_pulse, o_sel_inc_pulse, o_sel_dec_pulse, o_btn_level} !== 6'b000000) begin
         failures++;
         $display("[TB] FAIL rstmid_clear: got wr=%b inc=%b dec=%b level=%b want all 0",
                  o_wr_pulse, o_sel_inc_pulse, o_sel_dec_pulse, o_btn_level);
      end
      repeat (2) @(posedge clk);
      wait_ticks(1);
      rst_n = 1'b1;
      k = tick_cnt;
      exp_q.push_back('{btn: 2, tick: k + DB, width: 5, hits: 1});
      wait_ticks(DB + 4);
      btn[2] = 1'b1;
      wait_ticks(DB + 3);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL rstmid_event: got none, want btn=%0d tick=%0d", e.btn, e.tick);
         end else begin
            o = obs_q.pop_front();
            if (o.btn !== e.btn || o.tick !== e.tick || o.width !== e.width || o.hits !== e.hits) begin
               failures++;
               $display("[TB] FAIL rstmid_event: got btn=%0d tick=%0d width=%0d hits=%0d, want btn=%0d tick=%0d width=%0d hits=%0d",
                        o.btn, o.tick, o.width, o.hits, e.btn, e.tick, e.width, e.hits);
            end
         end
      end
      checks++;
      if (obs_q.size() !== 0) begin failures++; $display("[TB] FAIL rstmid_extra: got %0d extra events want 0", obs_q.size()); end
      obs_q.delete();
   endtask

   task automatic test_autorepeat;
      ev_t e, o;
      int  k;
      k = tick_cnt;
      btn[1] = 1'b0;
      exp_q.push_back('{btn: 1, tick: k + DB, width: 5, hits: 1});
`ifdef BUTTON_AUTOREPEAT_EN
      for (int r = 0; r < 3; r++)
         exp_q.push_back('{btn: 1, tick: k + DB + RD + r * RP, width: 5, hits: 1});
`endif
      wait_ticks(80);
      btn[1] = 1'b1;
      wait_ticks(DB + 3);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL repeat_event: got none, want btn=%0d tick=%0d", e.btn, e.tick);
         end else begin
            o = obs_q.pop_front();
            if (o.btn !== e.btn || o.tick !== e.tick || o.width !== e.width || o.hits !== e.hits) begin
               failures++;
               $display("[TB] FAIL repeat_event: got btn=%0d tick=%0d width=%0d hits=%0d, want btn=%0d tick=%0d width=%0d hits=%0d",
                        o.btn, o.tick, o.width, o.hits, e.btn, e.tick, e.width, e.hits);
            end
         end
      end
      checks++;
      if (obs_q.size() !== 0) begin failures++; $display("[TB] FAIL repeat_extra: got %0d extra events want 0", obs_q.size()); end
      obs_q.delete();
   endtask

   initial begin
      $display("[TB] starting button_conditioner bench");
      test_reset();
      test_bounce();
      test_glitch();
      test_conflict();
      test_back_to_back();
      test_reset_mid_pulse();
      test_autorepeat();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_TICKS, default 4: consecutive i_ena ticks of stable level needed to accept a press or release; legal range 1..255.
REQ-002 Parameter BTN_ACTIVE_LOW, default 1: when 1, raw button inputs read 0 while pressed.
REQ-003 Parameter REPEAT_DELAY, default 50: i_ena ticks a button must be held before auto-repeat starts; used only with BUTTON_AUTOREPEAT_EN.
REQ-004 Parameter REPEAT_PERIOD, default 10: i_ena ticks between auto-repeat pulses; used only with BUTTON_AUTOREPEAT_EN.
REQ-005 i_clk  input  1  system clock; all state changes on its rising edge.
REQ-006 i_reset_n  input  1  reset, asynchronous, active-low.
REQ-007 i_ena  input  1  sample strobe, one i_clk cycle wide, shared with the downstream input_control.
REQ-008 i_btn  input  3  raw asynchronous buttons: bit0 = write, bit1 = select-increment, bit2 = select-decrement.
REQ-009 o_wr_pulse  output  1  debounced write-press event.
REQ-010 o_sel_inc_pulse  output  1  debounced increment event.
REQ-011 o_sel_dec_pulse  output  1  debounced decrement event.
REQ-012 o_btn_level  output  3  debounced pressed level per button, 1 = pressed.

Function
REQ-013 Each i_btn bit SHALL pass through a 2-flop synchronizer, then be inverted when BTN_ACTIVE_LOW = 1, giving a synchronized pressed level.
REQ-014 Each button SHALL have its own debounce FSM with states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT, plus an 8-bit stability counter that advances only on i_ena.
REQ-015 IDLE: on an i_ena tick with the level pressed, go to PRESS_WAIT and set the counter to 1.
REQ-016 PRESS_WAIT: on an i_ena tick with the level pressed, increment the counter; when it reaches DEBOUNCE_TICKS, go to HELD.
REQ-017 PRESS_WAIT: on an i_ena tick with the level released, return to IDLE and clear the counter.
REQ-018 HELD and RELEASE_WAIT SHALL mirror REQ-015 to REQ-017 for the release direction: HELD goes to RELEASE_WAIT, reaching DEBOUNCE_TICKS returns to IDLE, and a renewed press returns to HELD.
REQ-019 o_btn_level SHALL be 1 in HELD and RELEASE_WAIT, and 0 in IDLE and PRESS_WAIT.
REQ-020 On the PRESS_WAIT to HELD transition, the corresponding event output SHALL go high on the next i_clk edge.
REQ-021 An event output SHALL stay high until the i_clk edge that follows the next i_ena tick, so that downstream logic sampling on i_ena sees exactly one asserted sample.
REQ-022 Event outputs SHALL be registered outputs.
REQ-023 If increment and decrement events arise on the same i_ena tick, both SHALL be suppressed.
REQ-024 A write event arising on the same tick as increment or decrement SHALL be emitted unaffected.
REQ-025 Input changes between i_ena ticks SHALL have no effect on any FSM or counter.
REQ-026 A press shorter than DEBOUNCE_TICKS ticks SHALL produce no event.

Reset
REQ-027 Asserting i_reset_n low SHALL, asynchronously, put every FSM in IDLE, clear all counters and synchronizer flops, and drive every output to 0.
REQ-028 A button still pressed when reset releases SHALL produce an event after DEBOUNCE_TICKS i_ena ticks.
REQ-029 Reset asserted mid-pulse SHALL clear the pulse immediately, and the pulse SHALL NOT reappear afterwards.

Configuration
REQ-030 Macro BUTTON_AUTOREPEAT_EN SHALL control auto-repeat for increment and decrement only.
REQ-031 With BUTTON_AUTOREPEAT_EN defined: after REPEAT_DELAY ticks in HELD, an extra event SHALL be emitted, then one every REPEAT_PERIOD ticks until the state leaves HELD; each extra event follows REQ-021 and REQ-023.
REQ-032 Without BUTTON_AUTOREPEAT_EN: exactly one event SHALL be emitted per debounced press, and no repeat counters SHALL be synthesized.
REQ-033 The write button SHALL never auto-repeat.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding (2 bits), the button index constants (BTN_WR = 0, BTN_INC = 1, BTN_DEC = 2) and the counter width.
REQ-035 Sub-module button_debounce SHALL hold one synchronizer, FSM and counter, and SHALL be instantiated three times.
REQ-036 The pulse stretching, inc/dec conflict logic and auto-repeat logic SHALL live in the top level.

Verification
REQ-037 Bench SHALL use i_ena every 5 i_clk cycles and DEBOUNCE_TICKS = 4.
REQ-038 Bounce test: toggle i_btn[0] every 2 ticks for 10 ticks, then hold it pressed for 6 ticks -> exactly one o_wr_pulse, asserted 4 ticks after the final stable press.
REQ-039 Glitch test: a 3-tick press on i_btn[1] -> no o_sel_inc_pulse, and o_btn_level[1] stays 0.
REQ-040 Pulse width test: every event pulse -> high for exactly one i_ena period, with exactly one high sample at i_ena.
REQ-041 Conflict test: press i_btn[1] and i_btn[2] together -> no inc or dec event; pressing i_btn[0] at the same time -> o_wr_pulse still emitted.
REQ-042 Reset test: drop i_reset_n while o_sel_dec_pulse is high -> all outputs 0 in the same cycle; with the button still held after release -> a new event after 4 ticks.
REQ-043 Auto-repeat test, with BUTTON_AUTOREPEAT_EN defined: hold i_btn[1] for 80 ticks with REPEAT_DELAY = 50 and REPEAT_PERIOD = 10 -> 4 increment events in total (1 initial + 3 repeats); without the macro -> exactly 1.
